// File: rtl/alu_arbiter_if.sv
// Request, response and ALU-side signals of the shared add/sub ALU arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the ALU.
interface alu_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned OP_W = 3;

  logic                  i_req0_valid;
  logic                  i_req1_valid;
  logic                  o_req0_ready;
  logic                  o_req1_ready;
  logic [OP_W-1:0]       i_req0_op;
  logic [OP_W-1:0]       i_req1_op;
  logic [DATA_WIDTH-1:0] i_req0_a;
  logic [DATA_WIDTH-1:0] i_req0_b;
  logic [DATA_WIDTH-1:0] i_req1_a;
  logic [DATA_WIDTH-1:0] i_req1_b;

  logic                  o_rsp0_valid;
  logic                  o_rsp1_valid;
  logic                  i_rsp0_ready;
  logic                  i_rsp1_ready;
  logic [DATA_WIDTH-1:0] o_rsp_data;
  logic                  o_rsp_overflow;
  logic                  o_rsp_illegal;

  logic [OP_W-1:0]       o_alu_op;
  logic [DATA_WIDTH-1:0] o_alu_a;
  logic [DATA_WIDTH-1:0] o_alu_b;
  logic [DATA_WIDTH-1:0] i_alu_data;
  logic                  i_alu_overflow;
  logic                  o_busy;

  modport slave (
    input  i_req0_valid, i_req1_valid, i_req0_op, i_req1_op,
           i_req0_a, i_req0_b, i_req1_a, i_req1_b,
           i_rsp0_ready, i_rsp1_ready, i_alu_data, i_alu_overflow,
    output o_req0_ready, o_req1_ready, o_rsp0_valid, o_rsp1_valid,
           o_rsp_data, o_rsp_overflow, o_rsp_illegal,
           o_alu_op, o_alu_a, o_alu_b, o_busy
  );

  modport master (
    output i_req0_valid, i_req1_valid, i_req0_op, i_req1_op,
           i_req0_a, i_req0_b, i_req1_a, i_req1_b,
           i_rsp0_ready, i_rsp1_ready, i_alu_data, i_alu_overflow,
    input  o_req0_ready, o_req1_ready, o_rsp0_valid, o_rsp1_valid,
           o_rsp_data, o_rsp_overflow, o_rsp_illegal,
           o_alu_op, o_alu_a, o_alu_b, o_busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter and sequencer for the shared add/sub ALU.
// One operation in flight: accept (IDLE) -> ALU evaluates (EXEC) -> response held (RESP).
module alu_arbiter #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic          i_clk,
  input logic          i_rst_n,
  alu_arbiter_if.slave bus
);
  localparam int unsigned     OP_W   = 3;
  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic                  last_grant_q;
  logic                  owner_q;
  logic                  grant0;
  logic                  grant1;
  logic                  accept;
  logic                  take;
  logic                  op_legal;
  logic [OP_W-1:0]       alu_op_q;
  logic [DATA_WIDTH-1:0] alu_a_q;
  logic [DATA_WIDTH-1:0] alu_b_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic                  rsp_ovf_q;
  logic                  rsp_ill_q;
  logic                  rsp0_valid_q;
  logic                  rsp1_valid_q;
  logic                  busy_q;

  assign op_legal = (alu_op_q == OP_ADD) || (alu_op_q == OP_SUB);

  // Next state and grant; on a tie the requester that was not granted last wins.
  always_comb begin
    state_d = state_q;
    grant0  = 1'b0;
    grant1  = 1'b0;
    accept  = 1'b0;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        grant0 = bus.i_req0_valid && (!bus.i_req1_valid || last_grant_q);
        grant1 = bus.i_req1_valid && (!bus.i_req0_valid || !last_grant_q);
        accept = grant0 || grant1;
        if (accept) state_d = EXEC;
      end
      EXEC: state_d = RESP;
      RESP: begin
        take = owner_q ? bus.i_rsp1_ready : bus.i_rsp0_ready;
        if (take) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_data_q   <= '0;
      rsp_ovf_q    <= 1'b0;
      rsp_ill_q    <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= (state_d != IDLE);
      rsp0_valid_q <= (state_d == RESP) && !owner_q;
      rsp1_valid_q <= (state_d == RESP) && owner_q;
      if (accept) begin
        owner_q      <= grant1;
        last_grant_q <= grant1;
        alu_op_q     <= grant1 ? bus.i_req1_op : bus.i_req0_op;
        alu_a_q      <= grant1 ? bus.i_req1_a  : bus.i_req0_a;
        alu_b_q      <= grant1 ? bus.i_req1_b  : bus.i_req0_b;
      end
      // Capture the ALU result; illegal ops report a zero result instead.
      if (state_q == EXEC) begin
        rsp_data_q <= op_legal ? bus.i_alu_data : '0;
        rsp_ovf_q  <= op_legal && bus.i_alu_overflow;
        rsp_ill_q  <= !op_legal;
      end
    end
  end

  assign bus.o_req0_ready   = grant0;
  assign bus.o_req1_ready   = grant1;
  assign bus.o_rsp0_valid   = rsp0_valid_q;
  assign bus.o_rsp1_valid   = rsp1_valid_q;
  assign bus.o_rsp_data     = rsp_data_q;
  assign bus.o_rsp_overflow = rsp_ovf_q;
  assign bus.o_rsp_illegal  = rsp_ill_q;
  assign bus.o_alu_op       = alu_op_q;
  assign bus.o_alu_a        = alu_a_q;
  assign bus.o_alu_b        = alu_b_q;
  assign bus.o_busy         = busy_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed cases plus randomized traffic against an arithmetic model.
// A behavioural add/sub ALU closes the loop from o_alu_* back to i_alu_*.
module tb_alu_arbiter;
  localparam int unsigned DW = 32;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  alu_arbiter_if #(.DATA_WIDTH(DW)) bus ();
  alu_arbiter #(.DATA_WIDTH(DW)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU stub: sign-bit overflow rules, result computed for every op code
  logic [DW-1:0] alu_res;
  assign alu_res = (bus.o_alu_op == 3'd1) ? bus.o_alu_a - bus.o_alu_b : bus.o_alu_a + bus.o_alu_b;
  assign bus.i_alu_data = alu_res;
  assign bus.i_alu_overflow = (bus.o_alu_op == 3'd1)
      ? ((bus.o_alu_a[DW-1] != bus.o_alu_b[DW-1]) && (alu_res[DW-1] != bus.o_alu_a[DW-1]))
      : ((bus.o_alu_a[DW-1] == bus.o_alu_b[DW-1]) && (alu_res[DW-1] != bus.o_alu_a[DW-1]));

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference result from exact integer arithmetic
  function automatic void ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] d, output logic o, output logic il);
    longint r;
    if (op > 3'd1) begin
      d = 32'd0; o = 1'b0; il = 1'b1;
    end else begin
      r  = (op == 3'd0) ? longint'($signed(a)) + longint'($signed(b))
                        : longint'($signed(a)) - longint'($signed(b));
      d  = 32'(r);
      o  = (r > 64'sh7FFF_FFFF) || (r < -64'sh8000_0000);
      il = 1'b0;
    end
  endfunction

  task automatic set_req(input int n, input logic v, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    if (n == 0) begin
      bus.i_req0_valid = v; bus.i_req0_op = op; bus.i_req0_a = a; bus.i_req0_b = b;
    end else begin
      bus.i_req1_valid = v; bus.i_req1_op = op; bus.i_req1_a = a; bus.i_req1_b = b;
    end
  endtask

  task automatic set_rr(input int n, input logic v);
    if (n == 0) bus.i_rsp0_ready = v;
    else        bus.i_rsp1_ready = v;
  endtask

  function automatic logic rdy(input int n);
    return (n == 0) ? bus.o_req0_ready : bus.o_req1_ready;
  endfunction

  function automatic logic rspv(input int n);
    return (n == 0) ? bus.o_rsp0_valid : bus.o_rsp1_valid;
  endfunction

  task automatic idle_inputs();
    set_req(0, 1'b0, 3'd0, 32'd0, 32'd0);
    set_req(1, 1'b0, 3'd0, 32'd0, 32'd0);
    set_rr(0, 1'b0);
    set_rr(1, 1'b0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ready0"},   64'(bus.o_req0_ready),   64'd0);
    chk({tag, "_ready1"},   64'(bus.o_req1_ready),   64'd0);
    chk({tag, "_rsp0v"},    64'(bus.o_rsp0_valid),   64'd0);
    chk({tag, "_rsp1v"},    64'(bus.o_rsp1_valid),   64'd0);
    chk({tag, "_data"},     64'(bus.o_rsp_data),     64'd0);
    chk({tag, "_ovf"},      64'(bus.o_rsp_overflow), 64'd0);
    chk({tag, "_ill"},      64'(bus.o_rsp_illegal),  64'd0);
    chk({tag, "_alu_op"},   64'(bus.o_alu_op),       64'd0);
    chk({tag, "_alu_a"},    64'(bus.o_alu_a),        64'd0);
    chk({tag, "_alu_b"},    64'(bus.o_alu_b),        64'd0);
    chk({tag, "_busy"},     64'(bus.o_busy),         64'd0);
  endtask

  // One isolated operation on requester n, response held for 'stall' extra cycles
  task automatic do_op(input int n, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int stall);
    logic [31:0] ed;
    logic        eo;
    logic        ei;
    ref_alu(op, a, b, ed, eo, ei);
    @(negedge clk);
    set_req(n, 1'b1, op, a, b);
    #1;
    chk("op_ready_own",   64'(rdy(n)),     64'd1);
    chk("op_ready_other", 64'(rdy(1 - n)), 64'd0);
    @(posedge clk);
    @(negedge clk);
    set_req(n, 1'b0, 3'd0, 32'd0, 32'd0);
    #1;
    chk("exec_busy",   64'(bus.o_busy),  64'd1);
    chk("exec_rspv",   64'(rspv(n)),     64'd0);
    chk("exec_alu_op", 64'(bus.o_alu_op), 64'(op));
    chk("exec_alu_a",  64'(bus.o_alu_a),  64'(a));
    chk("exec_alu_b",  64'(bus.o_alu_b),  64'(b));
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i <= stall; i++) begin
      #1;
      chk("rsp_valid_own",   64'(rspv(n)),            64'd1);
      chk("rsp_valid_other", 64'(rspv(1 - n)),        64'd0);
      chk("rsp_data",        64'(bus.o_rsp_data),     64'(ed));
      chk("rsp_ovf",         64'(bus.o_rsp_overflow), 64'(eo));
      chk("rsp_ill",         64'(bus.o_rsp_illegal),  64'(ei));
      if (i < stall) @(negedge clk);
    end
    set_rr(n, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_rr(n, 1'b0);
    #1;
    chk("done_rspv", 64'(rspv(n)),    64'd0);
    chk("done_busy", 64'(bus.o_busy), 64'd0);
  endtask

  function automatic logic [2:0] rnd_op();
    if ($urandom_range(0, 7) == 0) return 3'($urandom_range(2, 7));
    return 3'($urandom_range(0, 1));
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0000;
      default: return 32'($urandom);
    endcase
  endfunction

  // Transaction-level model: per-requester pending ops, one op in flight, round-robin on ties
  task automatic run_random(input int cycles, input int cont_cycles);
    bit          pv [2];
    logic [2:0]  pop [2];
    logic [31:0] pa [2];
    logic [31:0] pb [2];
    bit          rr [2];
    bit          inflight;
    bit          cont;
    int          age, owner, last, win, n_grant, last_acc;
    logic [31:0] ed;
    logic        eo, ei;
    inflight = 1'b0; age = 0; owner = 0; last = 1; n_grant = 0; last_acc = 0;
    ed = 32'd0; eo = 1'b0; ei = 1'b0;
    for (int n = 0; n < 2; n++) begin
      pv[n] = 1'b0; pop[n] = 3'd0; pa[n] = 32'd0; pb[n] = 32'd0; rr[n] = 1'b0;
    end
    for (int cyc = 0; cyc < cycles; cyc++) begin
      cont = (cyc < cont_cycles);
      @(negedge clk);
      for (int n = 0; n < 2; n++) begin
        if (!pv[n] && (cont || $urandom_range(0, 99) < 40)) begin
          pv[n]  = 1'b1;
          pop[n] = cont ? 3'd0 : rnd_op();
          pa[n]  = rnd_val();
          pb[n]  = rnd_val();
        end
        set_req(n, pv[n], pop[n], pa[n], pb[n]);
        rr[n] = cont || ($urandom_range(0, 99) < 55);
        set_rr(n, rr[n]);
      end
      #1;
      win = -1;
      if (!inflight) begin
        if (pv[0] && pv[1]) win = (last == 1) ? 0 : 1;
        else if (pv[0])     win = 0;
        else if (pv[1])     win = 1;
      end
      chk("rnd_ready0", 64'(bus.o_req0_ready), 64'(win == 0));
      chk("rnd_ready1", 64'(bus.o_req1_ready), 64'(win == 1));
      chk("rnd_busy",   64'(bus.o_busy),       64'(inflight));
      chk("rnd_rsp0v",  64'(bus.o_rsp0_valid), 64'(inflight && age >= 1 && owner == 0));
      chk("rnd_rsp1v",  64'(bus.o_rsp1_valid), 64'(inflight && age >= 1 && owner == 1));
      if (inflight && age >= 1) begin
        chk("rnd_data", 64'(bus.o_rsp_data),     64'(ed));
        chk("rnd_ovf",  64'(bus.o_rsp_overflow), 64'(eo));
        chk("rnd_ill",  64'(bus.o_rsp_illegal),  64'(ei));
      end
      if (win >= 0) begin
        if (cont) begin
          chk("alt_order", 64'(bus.o_req1_ready), 64'(n_grant % 2));
          if (n_grant > 0) chk("accept_spacing", 64'(cyc - last_acc), 64'd3);
        end
        n_grant++;
        last_acc = cyc;
        inflight = 1'b1;
        age      = 0;
        owner    = win;
        last     = win;
        ref_alu(pop[win], pa[win], pb[win], ed, eo, ei);
        pv[win]  = 1'b0;
      end else if (inflight) begin
        if (age >= 1 && rr[owner]) inflight = 1'b0;
        else age++;
      end
    end
  endtask

  initial begin
    logic [31:0] ed;
    logic        eo, ei;
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    idle_inputs();
    #1;
    check_reset("rst_hold");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_reset("rst_rel");

    do_op(0, 3'd0, 32'h0000_0005, 32'h0000_0003, 0);
    do_op(1, 3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 0);
    do_op(1, 3'd1, 32'h8000_0000, 32'h0000_0001, 0);
    do_op(1, 3'd1, 32'h0000_0003, 32'h0000_0005, 0);
    do_op(0, 3'd5, 32'h0000_1234, 32'h0000_0001, 2);

    // Response stall on req0 while req1 waits
    @(negedge clk);
    set_req(0, 1'b1, 3'd1, 32'd100, 32'd42);
    #1;
    chk("stall_ready0", 64'(bus.o_req0_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    set_req(0, 1'b0, 3'd0, 32'd0, 32'd0);
    set_req(1, 1'b1, 3'd0, 32'hA5A5_0000, 32'h0000_5A5A);
    set_rr(1, 1'b1);
    #1;
    chk("stall_exec_ready1", 64'(bus.o_req1_ready), 64'd0);
    @(posedge clk);
    ref_alu(3'd1, 32'd100, 32'd42, ed, eo, ei);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("stall_rsp0v",  64'(bus.o_rsp0_valid), 64'd1);
      chk("stall_rsp1v",  64'(bus.o_rsp1_valid), 64'd0);
      chk("stall_data",   64'(bus.o_rsp_data),   64'(ed));
      chk("stall_ready1", 64'(bus.o_req1_ready), 64'd0);
    end
    set_rr(0, 1'b1);
    #1;
    chk("stall_take_ready1", 64'(bus.o_req1_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    set_rr(0, 1'b0);
    #1;
    chk("stall_after_rsp0v",   64'(bus.o_rsp0_valid), 64'd0);
    chk("stall_after_ready1",  64'(bus.o_req1_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    set_req(1, 1'b0, 3'd0, 32'd0, 32'd0);
    #1;
    chk("stall_r1_alu_a", 64'(bus.o_alu_a), 64'h0000_0000_A5A5_0000);
    ref_alu(3'd0, 32'hA5A5_0000, 32'h0000_5A5A, ed, eo, ei);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("stall_r1_rsp1v", 64'(bus.o_rsp1_valid), 64'd1);
    chk("stall_r1_data",  64'(bus.o_rsp_data),   64'(ed));
    @(posedge clk);
    @(negedge clk);
    set_rr(1, 1'b0);
    #1;
    chk("stall_r1_done", 64'(bus.o_rsp1_valid), 64'd0);

    // Reset during EXEC drops the operation
    @(negedge clk);
    set_req(0, 1'b1, 3'd0, 32'hDEAD_0000, 32'h0000_BEEF);
    @(posedge clk);
    @(negedge clk);
    set_req(0, 1'b0, 3'd0, 32'd0, 32'd0);
    #1;
    chk("midrst_busy_before", 64'(bus.o_busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("midrst_no_rsp0", 64'(bus.o_rsp0_valid), 64'd0);
      chk("midrst_no_rsp1", 64'(bus.o_rsp1_valid), 64'd0);
      chk("midrst_idle",    64'(bus.o_busy),       64'd0);
    end
    do_op(0, 3'd1, 32'h0000_0010, 32'h0000_0020, 1);

    // Randomized traffic from a fresh reset, saturated at first
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_random(800, 40);

    @(negedge clk);
    idle_inputs();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
